// File: rtl/ccgrcg5_bist_seq.sv
// BIST sequencer for the CCGRCG5 netlist: applies vectors, waits SETTLE cycles, compacts f1..f15 into a MISR.
// Optional duplicate-output check is built only when CCG_DUP_CHECK_EN is defined.
module ccgrcg5_bist_seq #(
  parameter int              IN_W   = 10,
  parameter int              OUT_W  = 15,
  parameter int              SETTLE = 2,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [IN_W-1:0]   vec_in,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_x,
  input  logic [OUT_W-1:0]  dut_f,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [IN_W:0]     vec_cnt,
  output logic [IN_W:0]     hit_cnt,
  output logic              chk_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [IN_W:0]    vcnt_q, vcnt_d;
  logic [IN_W:0]    hcnt_q, hcnt_d;
  logic [SIG_W-1:0] misr_next;
  logic             start_fire;
  logic             capt_fire;

  assign start_fire = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
  assign capt_fire  = !abort && (state_q == S_CAPT);
  assign misr_next  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-OUT_W){1'b0}}, dut_f};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    wcnt_d  = wcnt_q;
    sig_d   = sig_q;
    vcnt_d  = vcnt_q;
    hcnt_d  = hcnt_q;
    // Abort beats everything, including a same-cycle start; all results stay frozen.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sig_d   = '0;
            vcnt_d  = '0;
            hcnt_d  = '0;
            mode_d  = mode;
            x_d     = mode ? vec_in : '0;
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          wcnt_d  = WAIT_LOAD;
          state_d = (SETTLE == 0) ? S_CAPT : S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q == '0) state_d = S_CAPT;
          else              wcnt_d  = wcnt_q - CNT_W'(1);
        end
        S_CAPT: begin
          sig_d  = misr_next;
          vcnt_d = vcnt_q + (IN_W+1)'(1);
          hcnt_d = hcnt_q + {{IN_W{1'b0}}, dut_f[0]};
          if (mode_q || (&x_q)) begin
            state_d = S_DONE;
          end else begin
            x_d     = x_q + IN_W'(1);
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      x_q     <= '0;
      wcnt_q  <= '0;
      sig_q   <= '0;
      vcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      wcnt_q  <= wcnt_d;
      sig_q   <= sig_d;
      vcnt_q  <= vcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

`ifdef CCG_DUP_CHECK_EN
  // Group A: f1-f7,f12,f14,f15; group B: f8-f11,f13. Each group must be uniform.
  logic [9:0] grp_a;
  logic [4:0] grp_b;
  logic       dup_bad;
  logic       chk_q, chk_d;

  assign grp_a   = {dut_f[14], dut_f[13], dut_f[11], dut_f[6:0]};
  assign grp_b   = {dut_f[12], dut_f[10:7]};
  assign dup_bad = !((&grp_a) || !(|grp_a)) || !((&grp_b) || !(|grp_b));

  always_comb begin
    chk_d = chk_q;
    if (start_fire)              chk_d = 1'b0;
    else if (capt_fire && dup_bad) chk_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 1'b0;
    else        chk_q <= chk_d;
  end

  assign chk_err = chk_q;
`else
  logic unused_fire;
  assign unused_fire = start_fire ^ capt_fire;
  assign chk_err     = 1'b0;
`endif

  assign dut_x     = x_q;
  assign busy      = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CAPT);
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;
  assign vec_cnt   = vcnt_q;
  assign hit_cnt   = hcnt_q;

endmodule

// File: tb/tb_ccgrcg5_bist_seq.sv
// Scoreboard bench for ccgrcg5_bist_seq: a behavioural netlist stands in for CCGRCG5, each run's
// expected result is queued at start and checked by a monitor when done rises.
module tb_ccgrcg5_bist_seq;
  localparam int          IN_W   = 10;
  localparam int          OUT_W  = 15;
  localparam int          SETTLE = 2;
  localparam int          SIG_W  = 16;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam logic [14:0] A_MASK = 15'h687F;
  localparam logic [14:0] B_MASK = 15'h1780;

  typedef struct {
    logic [15:0] sig;
    logic [10:0] vec;
    logic [10:0] hit;
    logic        chk;
    int          cycles;
    int          start_n;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [IN_W-1:0]   vec_in = '0;
  logic              abort = 1'b0;
  logic [IN_W-1:0]   dut_x;
  logic [OUT_W-1:0]  dut_f;
  logic              busy, done, chk_err;
  logic [SIG_W-1:0]  signature;
  logic [IN_W:0]     vec_cnt, hit_cnt;

  logic [14:0] lut [1024];
  bit          use_lut = 1'b0;
  bit          force_en = 1'b0;
  logic [9:0]  force_vec = '0;
  logic [14:0] force_val = '0;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;
  logic done_prev = 1'b0;

  ccgrcg5_bist_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .SIG_W(SIG_W), .POLY(POLY)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_in(vec_in), .abort(abort),
    .dut_x(dut_x), .dut_f(dut_f), .busy(busy), .done(done), .signature(signature),
    .vec_cnt(vec_cnt), .hit_cnt(hit_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Stand-in netlist: f1 = x0&x4 on all of group A, x1^x9 on group B, or a random table.
  function automatic logic [14:0] model_f(input logic [9:0] x, input bit ul, input bit fe,
                                          input logic [9:0] fv, input logic [14:0] fval,
                                          input logic [14:0] lv);
    if (fe && x == fv) return fval;
    if (ul) return lv;
    return ((x[0] & x[4]) ? A_MASK : 15'h0) | ((x[1] ^ x[9]) ? B_MASK : 15'h0);
  endfunction

  function automatic bit dup_bad(input logic [14:0] f);
    logic [14:0] a, b;
    a = f & A_MASK;
    b = f & B_MASK;
    return !(a == 15'h0 || a == A_MASK) || !(b == 15'h0 || b == B_MASK);
  endfunction

  always_comb dut_f = model_f(dut_x, use_lut, force_en, force_vec, force_val, lut[dut_x]);

  function automatic exp_t model_run(input bit m, input logic [9:0] v, input int nvec);
    exp_t e;
    int   s, vc, hc;
    logic [9:0]  x;
    logic [14:0] f;
    s = 0; vc = 0; hc = 0;
    e.chk = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      x = m ? v : 10'(i);
      f = model_f(x, use_lut, force_en, force_vec, force_val, lut[x]);
      s = ((s * 2) % 65536) ^ ((s >= 32768) ? int'(POLY) : 0) ^ int'(f);
      vc = vc + 1;
      hc = hc + int'(f[0]);
`ifdef CCG_DUP_CHECK_EN
      if (dup_bad(f)) e.chk = 1'b1;
`endif
    end
    e.sig = 16'(s);
    e.vec = 11'(vc);
    e.hit = 11'(hc);
    e.cycles = nvec * (SETTLE + 2);
    e.start_n = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per rising done and compares the results and run length.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n && done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("signature", 32'(signature), 32'(e.sig));
        check("vec_cnt", 32'(vec_cnt), 32'(e.vec));
        check("hit_cnt", 32'(hit_cnt), 32'(e.hit));
        check("chk_err", 32'(chk_err), 32'(e.chk));
        check("run_cycles", 32'(ncyc - e.start_n - 1), 32'(e.cycles));
      end
    end
    done_prev = done;
  end

  task automatic do_start(input bit m, input logic [9:0] v, input bit push);
    exp_t e;
    @(negedge clk); #1;
    mode = m; vec_in = v; start = 1'b1;
    if (push) begin
      e = model_run(m, v, m ? 1 : 1024);
      e.start_n = ncyc;
      sb.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    #1;
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    int   k;
    for (int i = 0; i < 1024; i++) lut[i] = 15'($urandom);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    check("rst_vec", 32'(vec_cnt), 32'd0);
    check("rst_hit", 32'(hit_cnt), 32'd0);
    check("rst_chk", 32'(chk_err), 32'd0);
    check("rst_dut_x", 32'(dut_x), 32'd0);
    #1 rst_n = 1'b1;

    // Exhaustive run on the structured netlist, with a stray start mid-run.
    do_start(1'b0, 10'h0, 1'b1);
    repeat (50) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    check("busy_after_stray_start", 32'(busy), 32'd1);
    wait_done(5000);
    check("exh_hit_256", 32'(hit_cnt), 32'd256);
    check("exh_vec_1024", 32'(vec_cnt), 32'd1024);

    // Single vector 0x011 producing 0x0001.
    force_en = 1'b1; force_vec = 10'h011; force_val = 15'h0001;
    do_start(1'b1, 10'h011, 1'b1);
    wait_done(20);
    check("single_sig_literal", 32'(signature), 32'h0001);
    force_en = 1'b0;

    // Back-to-back random single vectors, each restarted from DONE.
    use_lut = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_start(1'b1, 10'($urandom), 1'b1);
      check("restart_done_drop", 32'(done), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      wait_done(20);
    end

    // Duplicate-group violation on vector 7, then a clean run clears it.
    use_lut = 1'b0; force_en = 1'b1; force_vec = 10'd7; force_val = 15'h0003;
    do_start(1'b0, 10'h0, 1'b1);
    wait_done(5000);
    force_en = 1'b0;
    do_start(1'b1, 10'h3FF, 1'b1);
    wait_done(20);

    // Exhaustive run over the random table.
    use_lut = 1'b1;
    do_start(1'b0, 10'h0, 1'b1);
    wait_done(5000);

    // Abort in WAIT of vector 5.
    do_start(1'b0, 10'h0, 1'b0);
    k = 0;
    while (dut_x != 10'd5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_x5", 32'(dut_x), 32'd5);
    @(negedge clk); #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    e = model_run(1'b0, 10'h0, 5);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_vec", 32'(vec_cnt), 32'd5);
    check("abort_hit", 32'(hit_cnt), 32'(e.hit));
    check("abort_sig", 32'(signature), 32'(e.sig));
    // start together with abort: stays idle, results untouched.
    @(negedge clk); #1 start = 1'b1; abort = 1'b1;
    @(negedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("startabort_busy", 32'(busy), 32'd0);
    check("startabort_vec", 32'(vec_cnt), 32'd5);
    check("startabort_sig", 32'(signature), 32'(e.sig));

    // Asynchronous reset in the middle of a run.
    do_start(1'b0, 10'h0, 1'b0);
    repeat (100) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_vec", 32'(vec_cnt), 32'd0);
    check("midrst_sig", 32'(signature), 32'd0);
    check("midrst_dut_x", 32'(dut_x), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_done", 32'(done), 32'd0);
    check("queue_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
